// File: rtl/ram_write_arbiter_pkg.sv
// rtl/ram_write_arbiter_pkg.sv - shared defaults and arbiter types for the RAM write arbiter
package ram_write_arbiter_pkg;

    // Word and address widths shared with io_module
    localparam int unsigned DEF_N  = 32;
    localparam int unsigned DEF_AW = 20;

    // Default region base addresses shared with io_module
    localparam int unsigned BASE_A       = 5;
    localparam int unsigned BASE_B       = 10;
    localparam int unsigned BASE_U       = 5;
    localparam int unsigned BASE_T       = 0;
    localparam int unsigned BASE_CONTROL = 0;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_SERVE = 1'b1
    } arb_state_e;

    // Round-robin choice: 1 when requester 1 should win this cycle
    function automatic logic pick_req1(input logic ne0, input logic ne1, input logic last_grant);
        if (ne0 && ne1) begin
            return !last_grant;
        end
        return ne1;
    endfunction

endpackage

// File: rtl/ram_write_arbiter_word_fifo.sv
// rtl/ram_write_arbiter_word_fifo.sv - small per-requester word FIFO with flush
module word_fifo #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [N-1:0]  mem_q [DEPTH];
    logic [PW-2:0] wr_idx;

    // A push during flush becomes the first entry of the emptied FIFO
    assign wr_idx = flush ? '0 : wr_ptr_q[PW-2:0];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign dout  = mem_q[rd_ptr_q[PW-2:0]];

    // Next pointer values; flush overrides any pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = push ? PW'(1) : '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    // Pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are meaningless while empty so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/ram_write_arbiter.sv
// rtl/ram_write_arbiter.sv - round-robin arbiter sharing one RAM write port between two streams
module ram_write_arbiter
    import ram_write_arbiter_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned BASE0 = BASE_A,
    parameter int unsigned BASE1 = BASE_B
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start0,
    input  logic          start1,
    input  logic          store0,
    input  logic          store1,
    input  logic [N-1:0]  data0,
    input  logic [N-1:0]  data1,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [N-1:0]  ram_data,
    output logic          busy,
    output logic          overflow0,
    output logic          overflow1
);

    localparam logic [AW-1:0] B0 = AW'(BASE0);
    localparam logic [AW-1:0] B1 = AW'(BASE1);

    arb_state_e    state_q, state_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [N-1:0]  ram_data_q, ram_data_d;
    logic [AW-1:0] off0_q, off0_d;
    logic [AW-1:0] off1_q, off1_d;
    logic          last_grant_q, last_grant_d;
    logic          ovf0_q, ovf0_d;
    logic          ovf1_q, ovf1_d;

    logic          full0, empty0, full1, empty1;
    logic [N-1:0]  head0, head1;
    logic          ne0, ne1, win1;
    logic          pop0, pop1, push0, push1, drop0, drop1;

    assign ne0 = !empty0;
    assign ne1 = !empty1;

    word_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (push0),
        .pop   (pop0),
        .flush (start0),
        .din   (data0),
        .dout  (head0),
        .full  (full0),
        .empty (empty0)
    );

    word_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (push1),
        .pop   (pop1),
        .flush (start1),
        .din   (data1),
        .dout  (head1),
        .full  (full1),
        .empty (empty1)
    );

    // Grant, push acceptance and next-state for the arbiter FSM and write registers
    always_comb begin
        state_d      = state_q;
        win1         = pick_req1(ne0, ne1, last_grant_q);
        pop0         = 1'b0;
        pop1         = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        off0_d       = off0_q;
        off1_d       = off1_q;
        last_grant_d = last_grant_q;

        // SERVE covers every cycle in which a FIFO can hold data, so grants are
        // only evaluated there; a start on the granted requester cancels its write.
        if (state_q == ARB_SERVE) begin
            pop0 = ne0 && !win1 && !start0;
            pop1 = ne1 &&  win1 && !start1;
        end

        // Full FIFO still accepts when its head leaves this cycle or it is flushed
        push0 = store0 && (!full0 || pop0 || start0);
        push1 = store1 && (!full1 || pop1 || start1);
        drop0 = store0 && !push0;
        drop1 = store1 && !push1;

        if (pop0) begin
            ram_we_d     = 1'b1;
            ram_addr_d   = B0 + off0_q;
            ram_data_d   = head0;
            off0_d       = off0_q + AW'(1);
            last_grant_d = 1'b0;
        end else if (pop1) begin
            ram_we_d     = 1'b1;
            ram_addr_d   = B1 + off1_q;
            ram_data_d   = head1;
            off1_d       = off1_q + AW'(1);
            last_grant_d = 1'b1;
        end

        if (start0) begin
            off0_d = '0;
        end
        if (start1) begin
            off1_d = '0;
        end

        ovf0_d = start0 ? 1'b0 : (ovf0_q || drop0);
        ovf1_d = start1 ? 1'b0 : (ovf1_q || drop1);

        case (state_q)
            ARB_IDLE: begin
                if (push0 || push1) begin
                    state_d = ARB_SERVE;
                end
            end
            ARB_SERVE: begin
                if (!ne0 && !ne1 && !push0 && !push1) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            off0_q       <= '0;
            off1_q       <= '0;
            last_grant_q <= 1'b1;
            ovf0_q       <= 1'b0;
            ovf1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            off0_q       <= off0_d;
            off1_q       <= off1_d;
            last_grant_q <= last_grant_d;
            ovf0_q       <= ovf0_d;
            ovf1_q       <= ovf1_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign overflow0 = ovf0_q;
    assign overflow1 = ovf1_q;
    assign busy      = ne0 || ne1 || ram_we_q;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// tb/tb_ram_write_arbiter.sv - randomized and directed bench for ram_write_arbiter
module tb_ram_write_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MB0   = 5;
    localparam int unsigned MB1   = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1, store0, store1;
    logic [31:0] data0, data1;
    logic        ram_we, busy, overflow0, overflow1;
    logic [19:0] ram_addr;
    logic [31:0] ram_data;

    logic        w_store0;
    logic [31:0] w_data0;
    logic        w_we, w_busy, w_ov0, w_ov1;
    logic [19:0] w_addr;
    logic [31:0] w_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq0[$];
    logic [31:0] mq1[$];
    int unsigned m_off0, m_off1;
    logic        m_lg, m_we, m_ov0, m_ov1;
    logic [19:0] m_addr;
    logic [31:0] m_data;

    logic [19:0] la[$];
    logic [31:0] ld[$];
    logic [19:0] wa[$];

    always #5 clk = ~clk;

    ram_write_arbiter dut (
        .clk(clk), .reset(reset),
        .start0(start0), .start1(start1), .store0(store0), .store1(store1),
        .data0(data0), .data1(data1),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .busy(busy), .overflow0(overflow0), .overflow1(overflow1)
    );

    ram_write_arbiter #(.BASE0(32'h000F_FFFE)) dut_wrap (
        .clk(clk), .reset(reset),
        .start0(1'b0), .start1(1'b0), .store0(w_store0), .store1(1'b0),
        .data0(w_data0), .data1(32'h0),
        .ram_we(w_we), .ram_addr(w_addr), .ram_data(w_data),
        .busy(w_busy), .overflow0(w_ov0), .overflow1(w_ov1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        m_off0 = 0;
        m_off1 = 0;
        m_lg   = 1'b1;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_ov0  = 1'b0;
        m_ov1  = 1'b0;
    endtask

    // One clock of the reference: pick a winner from pre-push occupancy, pop, then flush/push
    task automatic model_step();
        int win;
        win = -1;
        if (mq0.size() > 0 && mq1.size() > 0) win = (m_lg == 1'b1) ? 0 : 1;
        else if (mq0.size() > 0) win = 0;
        else if (mq1.size() > 0) win = 1;
        if (win == 0 && start0) win = -1;
        if (win == 1 && start1) win = -1;
        m_we = (win >= 0);
        if (win == 0) begin
            m_addr = 20'((MB0 + m_off0) % (1 << 20));
            m_data = mq0.pop_front();
            m_off0 = m_off0 + 1;
            m_lg   = 1'b0;
        end else if (win == 1) begin
            m_addr = 20'((MB1 + m_off1) % (1 << 20));
            m_data = mq1.pop_front();
            m_off1 = m_off1 + 1;
            m_lg   = 1'b1;
        end
        if (start0) begin mq0.delete(); m_off0 = 0; m_ov0 = 1'b0; end
        if (start1) begin mq1.delete(); m_off1 = 0; m_ov1 = 1'b0; end
        if (store0) begin
            if (mq0.size() < DEPTH) mq0.push_back(data0); else m_ov0 = 1'b1;
        end
        if (store1) begin
            if (mq1.size() < DEPTH) mq1.push_back(data1); else m_ov1 = 1'b1;
        end
    endtask

    task automatic compare();
        logic m_busy;
        m_busy = (mq0.size() > 0) || (mq1.size() > 0) || m_we;
        chk("ram_we", 64'(ram_we), 64'(m_we));
        chk("ram_addr", 64'(ram_addr), 64'(m_addr));
        chk("ram_data", 64'(ram_data), 64'(m_data));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("overflow0", 64'(overflow0), 64'(m_ov0));
        chk("overflow1", 64'(overflow1), 64'(m_ov1));
        if (ram_we) begin la.push_back(ram_addr); ld.push_back(ram_data); end
        if (w_we) wa.push_back(w_addr);
    endtask

    task automatic cyc(input logic s0, input logic st0, input logic [31:0] d0,
                       input logic s1, input logic st1, input logic [31:0] d1);
        start0 = s0; store0 = st0; data0 = d0;
        start1 = s1; store1 = st1; data1 = d1;
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Asserts reset mid-cycle, checks outputs clear at once, releases after the next edge
    task automatic do_reset();
        start0 = 0; start1 = 0; store0 = 0; store1 = 0; data0 = 0; data1 = 0;
        w_store0 = 0; w_data0 = 0;
        reset = 1'b0;
        #2;
        model_reset();
        chk("rst_ram_we", 64'(ram_we), 64'h0);
        chk("rst_ram_addr", 64'(ram_addr), 64'h0);
        chk("rst_ram_data", 64'(ram_data), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_overflow", 64'({overflow1, overflow0}), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int idx;
        logic [19:0] exp_a[6];
        logic [31:0] exp_d[6];
        logic [19:0] exp_w[4];
        reset = 1'b0;
        start0 = 0; start1 = 0; store0 = 0; store1 = 0; data0 = 0; data1 = 0;
        w_store0 = 0; w_data0 = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Single store on requester 0
        cyc(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        chk("t1_busy_after_push", 64'(busy), 64'h1);
        idle(1);
        chk("t1_we", 64'(ram_we), 64'h1);
        chk("t1_addr", 64'(ram_addr), 64'h5);
        chk("t1_data", 64'(ram_data), 64'hDEADBEEF);
        idle(1);
        chk("t1_busy_drop", 64'(busy), 64'h0);

        // Simultaneous stores alternate starting with requester 0
        do_reset();
        la.delete(); ld.delete();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'hA0 + i, 1'b0, 1'b1, 32'hB0 + i);
        idle(6);
        exp_a = '{20'd5, 20'd10, 20'd6, 20'd11, 20'd7, 20'd12};
        exp_d = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2};
        chk("t2_write_count", 64'(la.size()), 64'd6);
        for (int i = 0; i < 6 && i < la.size(); i++) begin
            chk("t2_addr", 64'(la[i]), 64'(exp_a[i]));
            chk("t2_data", 64'(ld[i]), 64'(exp_d[i]));
        end
        chk("t2_no_overflow", 64'({overflow1, overflow0}), 64'h0);

        // Flood both streams; FIFOs fill and overflow, one write per cycle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, $urandom, 1'b0, 1'b1, $urandom);
            if (i > 0) chk("t3_one_write_per_cycle", 64'(ram_we), 64'h1);
        end
        chk("t3_overflow0", 64'(overflow0), 64'h1);
        chk("t3_overflow1", 64'(overflow1), 64'h1);

        // Restart requester 1 mid-burst: buffered words vanish, overflow1 clears
        la.delete(); ld.delete();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("t4_overflow1_clear", 64'(overflow1), 64'h0);
        chk("t4_overflow0_kept", 64'(overflow0), 64'h1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234);
        idle(8);
        idx = -1;
        for (int i = 0; i < ld.size(); i++) if (ld[i] == 32'h1234 && idx < 0) idx = i;
        chk("t4_new_word_written", 64'(idx >= 0), 64'h1);
        if (idx >= 0) chk("t4_new_word_addr", 64'(la[idx]), 64'd10);

        // Reset while busy, then first store lands at base again
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, $urandom, 1'b0, 1'b1, $urandom);
        do_reset();
        cyc(1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 32'h0);
        idle(1);
        chk("t5_addr", 64'(ram_addr), 64'd5);
        chk("t5_data", 64'(ram_data), 64'h55);

        // Address wrap on the second instance
        wa.delete();
        for (int i = 0; i < 4; i++) begin
            w_store0 = 1'b1;
            w_data0 = 32'(i);
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        end
        w_store0 = 1'b0;
        idle(3);
        exp_w = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
        chk("t6_write_count", 64'(wa.size()), 64'd4);
        for (int i = 0; i < 4 && i < wa.size(); i++) chk("t6_wrap_addr", 64'(wa[i]), 64'(exp_w[i]));
        chk("t6_last_data", 64'(w_data), 64'h3);
        chk("t6_idle", 64'({w_busy, w_ov1, w_ov0}), 64'h0);

        // Randomized traffic with occasional block restarts
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 45, $urandom,
                $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 45, $urandom);
        end
        idle(10);
        chk("final_idle", 64'(busy), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_write_arbiter.md
Name: ram_write_arbiter

Overview:
- Shares one RAM write port between two decompressor output streams.
- Each stream issues single-cycle `store` pulses with a data word and has no backpressure. The arbiter buffers each stream in a small FIFO and generates a sequential address for it, as base plus a running offset.
- It grants the port round-robin, one write per cycle, and replaces the per-memory select/MDR multiplexing.
- Sits between the decompressor pair and a RAM instance.

Parameters:
- N, 32, data word width.
- AW, 20, RAM address width.
- DEPTH, 4, entries per requester FIFO (power of two, ≥2).
- BASE0, 5, base address of requester 0 region.
- BASE1, 10, base address of requester 1 region.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- start0  input  1  pulse: begin a new block on requester 0.
- start1  input  1  pulse: begin a new block on requester 1.
- store0  input  1  pulse: data0 is valid this cycle.
- store1  input  1  pulse: data1 is valid this cycle.
- data0  input  N  requester 0 word.
- data1  input  N  requester 1 word.
- ram_we  output  1  registered RAM write enable.
- ram_addr  output  AW  registered write address.
- ram_data  output  N  registered write data.
- busy  output  1  high while either FIFO is non-empty or ram_we is high.
- overflow0  output  1  sticky: requester 0 dropped a word.
- overflow1  output  1  sticky: requester 1 dropped a word.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both FIFOs empty; offsets = 0; last_grant = 1, so requester 0 wins first.
  - ram_we = 0, ram_addr = 0, ram_data = 0, busy = 0, overflow0 = overflow1 = 0.
  - Takes effect immediately, mid-burst included; in-flight and buffered words are discarded.
- Push:
  - store_i=1 with FIFO_i not full: push data_i.
  - FIFO_i full and not popped this same cycle: word dropped, overflow_i set.
  - FIFO_i full and popped this cycle: push accepted, no overflow.
- Arbitration, evaluated combinationally each cycle on FIFO non-empty flags (current-cycle pushes are not visible):
  - Neither non-empty: no grant.
  - Exactly one non-empty: grant it.
  - Both non-empty: grant the requester not equal to last_grant.
  - On a grant: pop the head; next edge drives ram_we=1, ram_addr = BASE_i + offset_i (modulo 2^AW), ram_data = head word; then offset_i += 1 and last_grant = i.
  - No grant: ram_we=0; ram_addr/ram_data hold their last values.
- Latency: store at edge t is written at edge t+1 (ram_we high during cycle t+1 → t+2) when uncontended. Under contention, a requester waits at most one extra cycle per pending word of the other requester.
- Throughput: sustained 1 write/cycle. Two simultaneous stores every cycle exceed capacity, so the FIFOs fill and overflow is flagged; upstream must average ≤1 store/cycle combined.
- Offset wrap: offset_i is AW bits. ram_addr = BASE_i + offset_i truncated to AW, so it wraps silently with no flag.
- start_i:
  - Flushes FIFO_i, clears offset_i and overflow_i.
  - If requester i is granted in the same cycle, the grant is cancelled (no write).
  - If store_i is asserted in the same cycle, that word is accepted as the first entry of the new block (offset 0).
  - start_i does not affect the other requester.
- busy = FIFO0 non-empty | FIFO1 non-empty | ram_we.

State machine (arbiter):
- IDLE: both empty; ram_we=0.
  - Leaves to SERVE when any FIFO is non-empty at a clock edge.
- SERVE: grant each cycle per the rules above.
  - Returns to IDLE when both FIFOs are empty after the pop and no push occurred.
- last_grant persists across IDLE.

Decomposition:
- Shared package: default base-address constants (A=5, B=10, U=5, T=0, control=0) and the N/AW defaults, so io_module and this block agree.
- One sub-module, word_fifo:
  - Parameters N, DEPTH.
  - Ports: push, pop, flush, din, dout (head, combinational), full, empty.
  - Pointer width clog2(DEPTH)+1.
  - Instantiated twice.

Test Plan:
- Reset, then single store0 with data0=0xDEADBEEF → next cycle ram_we=1, ram_addr=5, ram_data=0xDEADBEEF; busy drops the cycle after.
- store0 and store1 together for 3 cycles (0xA0..A2, 0xB0..B2) → writes alternate: A0@5, B0@10, A1@6, B1@11, A2@7, B2@12; no overflow.
- Both streams store every cycle for 10 cycles with DEPTH=4 → overflow flags set, exactly 1 write/cycle, written words are in per-stream order with no gaps in each address sequence.
- start1 pulse mid-burst with 3 words in FIFO1 → those words are never written; next store1 is written at address 10; overflow1 clears.
- Reset deasserted → asserted while busy → all outputs are 0 immediately; after release, the first store0 writes at address 5.
- BASE0 = 2^AW−2, four store0 words → addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
